wb_stage_param: RTL and testbench

WB_STAGE_PARAM -- requirements
Module: wb_stage_param

---
 rtl/wb_stage_param.sv | 130 +++++++++++++
 tb/tb_wb_stage_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_stage_param.sv
// rtl/wb_stage_param.sv - pipeline write-back stage: result select, load extraction, retire counter
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_param #(
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             stall,
   input  logic             flush,
   input  logic [1:0]       res_sel,
   input  logic [2:0]       load_f3,
   input  logic [1:0]       addr_lo,
   input  logic [XLEN-1:0]  alu_result,
   input  logic [XLEN-1:0]  read_data,
   input  logic [XLEN-1:0]  pc_plus4,
   input  logic [XLEN-1:0]  immed,
   input  logic [RA_W-1:0]  rd_in,
   input  logic             reg_write,
   output logic [XLEN-1:0]  wb_data,
   output logic [RA_W-1:0]  wb_rd,
   output logic             wb_we,
   output logic             misalign_err,
   output logic [CNT_W-1:0] retire_count
);

   logic            w_accept;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [XLEN-1:0] w_load;
   logic [XLEN-1:0] w_result;
   logic            w_misaligned;

   logic [XLEN-1:0] r_data;
   logic [RA_W-1:0] r_rd;
   logic            r_we;
   logic            r_err;

   assign w_accept = in_valid & ~stall & ~flush & rst;

   always_comb begin
      w_byte = read_data[7:0];
      case (addr_lo)
         2'd1:    w_byte = read_data[15:8];
         2'd2:    w_byte = read_data[23:16];
         2'd3:    w_byte = read_data[31:24];
         default: w_byte = read_data[7:0];
      endcase
   end

   assign w_half = addr_lo[1] ? read_data[31:16] : read_data[15:0];

   // Unlisted funct3 encodings fall through to the word path, both for data and alignment.
   always_comb begin
      w_load       = XLEN'($signed(read_data[31:0]));
      w_misaligned = 1'b0;
      case (load_f3)
         3'b000: w_load = XLEN'($signed(w_byte));
         3'b100: w_load = XLEN'(w_byte);
         3'b001: begin
            w_load       = XLEN'($signed(w_half));
            w_misaligned = addr_lo[0];
         end
         3'b101: begin
            w_load       = XLEN'(w_half);
            w_misaligned = addr_lo[0];
         end
         default: begin
            w_load       = XLEN'($signed(read_data[31:0]));
            w_misaligned = |addr_lo;
         end
      endcase
      if (res_sel != 2'b01) begin
         w_misaligned = 1'b0;
      end
   end

   always_comb begin
      w_result = alu_result;
      case (res_sel)
         2'b01:   w_result = w_load;
         2'b10:   w_result = pc_plus4;
         2'b11:   w_result = immed;
         default: w_result = alu_result;
      endcase
   end

   // Data and index hold whenever nothing is accepted; enables drop so no register is written twice.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_data <= '0;
         r_rd   <= '0;
         r_we   <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_we  <= 1'b0;
         r_err <= 1'b0;
         if (w_accept) begin
            r_data <= w_result;
            r_rd   <= rd_in;
            r_we   <= reg_write & (|rd_in) & ~w_misaligned;
            r_err  <= w_misaligned;
         end
      end
   end

   assign wb_data      = r_data;
   assign wb_rd        = r_rd;
   assign wb_we        = r_we;
   assign misalign_err = r_err;

`ifdef WB_RETIRE_CNT_EN
   logic [CNT_W-1:0] r_retire;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_retire <= '0;
      end else if (w_accept) begin
         r_retire <= r_retire + 1'b1;
      end
   end

   assign retire_count = r_retire;
`else
   assign retire_count = '0;
`endif

endmodule

// File: tb/tb_wb_stage_param.sv
// tb/tb_wb_stage_param.sv - table-driven scoreboard bench for wb_stage_param
// Retire-count expectations follow WB_RETIRE_CNT_EN as seen by this compile.
module tb_wb_stage_param;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        stall;
   logic        flush;
   logic [1:0]  res_sel;
   logic [2:0]  load_f3;
   logic [1:0]  addr_lo;
   logic [31:0] alu_result;
   logic [31:0] read_data;
   logic [31:0] pc_plus4;
   logic [31:0] immed;
   logic [4:0]  rd_in;
   logic        reg_write;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_we;
   logic        misalign_err;
   logic [3:0]  retire_count;

   wb_stage_param #(.XLEN(32), .RA_W(5), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
      .res_sel(res_sel), .load_f3(load_f3), .addr_lo(addr_lo),
      .alu_result(alu_result), .read_data(read_data), .pc_plus4(pc_plus4), .immed(immed),
      .rd_in(rd_in), .reg_write(reg_write),
      .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
      .misalign_err(misalign_err), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [1:0]  a;
      logic [31:0] alu;
      logic [31:0] rdat;
      logic [31:0] pc4;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        rw;
      logic [31:0] e_data;
      logic        e_we;
      logic        e_err;
   } vec_t;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      logic        err;
      logic        known;
      logic [3:0]  cnt;
   } exp_t;

   vec_t        tbl[$];
   exp_t        sb[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] m_data = '0;
   logic [4:0]  m_rd   = '0;
   logic        m_known = 1'b1;
   logic [3:0]  m_cnt  = '0;

   function automatic vec_t mk(input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] a,
                               input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc4,
                               input logic [31:0] imm, input logic [4:0] rd, input logic rw,
                               input logic [31:0] ed, input logic ewe, input logic eerr);
      vec_t v;
      v.sel = sel; v.f3 = f3; v.a = a; v.alu = alu; v.rdat = rdat; v.pc4 = pc4; v.imm = imm;
      v.rd = rd; v.rw = rw; v.e_data = ed; v.e_we = ewe; v.e_err = eerr;
      return v;
   endfunction

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s step%0d actual=%h required=%h", nm, id, act, req);
      end
   endtask

   task automatic step(input logic v, input logic s, input logic f, input logic r, input vec_t x, input int id);
      exp_t e;
      exp_t got;
      in_valid = v; stall = s; flush = f; rst = r;
      res_sel = x.sel; load_f3 = x.f3; addr_lo = x.a; alu_result = x.alu; read_data = x.rdat;
      pc_plus4 = x.pc4; immed = x.imm; rd_in = x.rd; reg_write = x.rw;
      e = '0;
      if (!r) begin
         m_data = '0; m_rd = '0; m_known = 1'b1; m_cnt = '0;
      end else if (v && !s && !f) begin
         m_data = x.e_data; m_rd = x.rd; m_known = !x.e_err;
         e.we = x.e_we; e.err = x.e_err;
`ifdef WB_RETIRE_CNT_EN
         m_cnt = m_cnt + 4'd1;
`endif
      end
      e.data = m_data; e.rd = m_rd; e.known = m_known; e.cnt = m_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk("wb_we", id, {31'd0, wb_we}, {31'd0, got.we});
      chk("misalign_err", id, {31'd0, misalign_err}, {31'd0, got.err});
      chk("retire_count", id, {28'd0, retire_count}, {28'd0, got.cnt});
      if (got.known) begin
         chk("wb_data", id, wb_data, got.data);
         chk("wb_rd", id, {27'd0, wb_rd}, {27'd0, got.rd});
      end
   endtask

   initial begin
      vec_t z;
      vec_t acc;
      z = '0;
      clk = 1'b0;
      // sel f3 a alu rdat pc4 imm rd rw | exp data we err
      tbl.push_back(mk(2'd1, 3'd0, 2'd3, 32'h11, 32'h80FF7F01, 32'h22, 32'h33, 5'd5, 1'b1, 32'hFFFFFF80, 1'b1, 1'b0));
      tbl.push_back(mk(2'd1, 3'd4, 2'd3, 32'h11, 32'h80FF7F01, 32'h22, 32'h33, 5'd5, 1'b1, 32'h00000080, 1'b1, 1'b0));
      tbl.push_back(mk(2'd1, 3'd0, 2'd0, 32'h11, 32'h80FF7F01, 32'h22, 32'h33, 5'd5, 1'b1, 32'h00000001, 1'b1, 1'b0));
      tbl.push_back(mk(2'd1, 3'd0, 2'd1, 32'h11, 32'h80FF7F01, 32'h22, 32'h33, 5'd4, 1'b1, 32'h0000007F, 1'b1, 1'b0));
      tbl.push_back(mk(2'd1, 3'd0, 2'd2, 32'h11, 32'h80FF7F01, 32'h22, 32'h33, 5'd4, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0));
      tbl.push_back(mk(2'd1, 3'd5, 2'd2, 32'h11, 32'h80011234, 32'h22, 32'h33, 5'd6, 1'b1, 32'h00008001, 1'b1, 1'b0));
      tbl.push_back(mk(2'd1, 3'd1, 2'd2, 32'h11, 32'h80011234, 32'h22, 32'h33, 5'd6, 1'b1, 32'hFFFF8001, 1'b1, 1'b0));
      tbl.push_back(mk(2'd1, 3'd1, 2'd0, 32'h11, 32'h80011234, 32'h22, 32'h33, 5'd6, 1'b1, 32'h00001234, 1'b1, 1'b0));
      tbl.push_back(mk(2'd1, 3'd5, 2'd0, 32'h11, 32'h8001F234, 32'h22, 32'h33, 5'd6, 1'b1, 32'h0000F234, 1'b1, 1'b0));
      tbl.push_back(mk(2'd1, 3'd1, 2'd1, 32'h11, 32'h80011234, 32'h22, 32'h33, 5'd6, 1'b1, 32'h0, 1'b0, 1'b1));
      tbl.push_back(mk(2'd1, 3'd5, 2'd3, 32'h11, 32'h80011234, 32'h22, 32'h33, 5'd6, 1'b1, 32'h0, 1'b0, 1'b1));
      tbl.push_back(mk(2'd1, 3'd2, 2'd0, 32'h11, 32'hDEADBEEF, 32'h22, 32'h33, 5'd7, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0));
      tbl.push_back(mk(2'd1, 3'd2, 2'd2, 32'h11, 32'hDEADBEEF, 32'h22, 32'h33, 5'd7, 1'b1, 32'h0, 1'b0, 1'b1));
      tbl.push_back(mk(2'd1, 3'd3, 2'd0, 32'h11, 32'h8BADF00D, 32'h22, 32'h33, 5'd8, 1'b1, 32'h8BADF00D, 1'b1, 1'b0));
      tbl.push_back(mk(2'd1, 3'd7, 2'd1, 32'h11, 32'h8BADF00D, 32'h22, 32'h33, 5'd8, 1'b1, 32'h0, 1'b0, 1'b1));
      tbl.push_back(mk(2'd1, 3'd0, 2'd0, 32'h11, 32'h00000081, 32'h22, 32'h33, 5'd0, 1'b1, 32'hFFFFFF81, 1'b0, 1'b0));
      tbl.push_back(mk(2'd0, 3'd2, 2'd1, 32'h1234, 32'h55, 32'h22, 32'h33, 5'd0, 1'b1, 32'h00001234, 1'b0, 1'b0));
      tbl.push_back(mk(2'd0, 3'd2, 2'd1, 32'hCAFE, 32'h55, 32'h22, 32'h33, 5'd9, 1'b1, 32'h0000CAFE, 1'b1, 1'b0));
      tbl.push_back(mk(2'd0, 3'd0, 2'd0, 32'hBEEF, 32'h55, 32'h22, 32'h33, 5'd9, 1'b0, 32'h0000BEEF, 1'b0, 1'b0));
      tbl.push_back(mk(2'd2, 3'd0, 2'd0, 32'h1, 32'h55, 32'h00001004, 32'h33, 5'd3, 1'b1, 32'h00001004, 1'b1, 1'b0));
      tbl.push_back(mk(2'd3, 3'd0, 2'd0, 32'h1, 32'h55, 32'h00001004, 32'hFFFFF800, 5'd31, 1'b1, 32'hFFFFF800, 1'b1, 1'b0));

      // reset state, with an instruction presented during reset that must be discarded
      step(1'b0, 1'b0, 1'b0, 1'b0, z, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, tbl[0], 1);

      foreach (tbl[i]) step(1'b1, 1'b0, 1'b0, 1'b1, tbl[i], 100 + i);

      // accept then three stall cycles: one write, then held data/rd with we low
      acc = mk(2'd0, 3'd0, 2'd0, 32'hABCD, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1, 32'h0000ABCD, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, acc, 200);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, tbl[17], 201 + i);
      // stall and flush together, flush of a misaligned load, then idle
      step(1'b1, 1'b1, 1'b1, 1'b1, tbl[17], 210);
      step(1'b1, 1'b0, 1'b1, 1'b1, tbl[9], 211);
      step(1'b0, 1'b0, 1'b0, 1'b1, tbl[17], 212);

      // reset mid-stream, then first accept afterwards
      step(1'b1, 1'b0, 1'b0, 1'b1, tbl[5], 220);
      step(1'b1, 1'b0, 1'b0, 1'b0, tbl[6], 221);
      step(1'b1, 1'b0, 1'b0, 1'b1, tbl[0], 222);

      // sixteen accepts from reset wrap the 4-bit counter back to 0
      step(1'b0, 1'b0, 1'b0, 1'b0, z, 230);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b1, tbl[i % 21], 240 + i);
      chk("wrap_count", 256, {28'd0, retire_count}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
